// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and nibble width.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla_sub_slice_4bit.sv
// Combinational 4-bit subtract slice (a - b - bin) built as a carry-lookahead adder on a + ~b + ~bin.
module cla_sub_slice_4bit
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [NIBBLE_W-1:0] nb;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign nb = ~b;
    assign g  = a & nb;
    assign p  = a ^ nb;

    // Carries expanded from generate/propagate so no carry ripples through the slice.
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign d    = p ^ c[NIBBLE_W-1:0];
    assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor computing A - B - Bin one nibble per cycle, LSB first, with valid/ready handshakes.
// Optional macro SUB_OVERFLOW_EN adds the signed-overflow output Ovf.
module nibble_serial_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    diff_reg;
    logic [IDX_W-1:0]    idx;
    logic                borrow;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] d_nib;
    logic                bout_nib;

    assign a_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_reg[idx*NIBBLE_W +: NIBBLE_W];

    cla_sub_slice_4bit u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (borrow),
        .d    (d_nib),
        .bout (bout_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The borrow register carries Bin into nibble 0 and the final borrow out after the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            idx      <= '0;
            borrow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        borrow   <= Bin;
                        diff_reg <= '0;
                        idx      <= '0;
                    end
                end
                CALC: begin
                    diff_reg[idx*NIBBLE_W +: NIBBLE_W] <= d_nib;
                    borrow <= bout_nib;
                    idx    <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Results are gated so a partially built difference is never visible outside DONE.
    assign Diff = out_valid ? diff_reg : '0;
    assign Bout = out_valid & borrow;
    assign Zero = out_valid & (diff_reg == '0);

`ifdef SUB_OVERFLOW_EN
    assign Ovf = out_valid & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (diff_reg[WIDTH-1] ^ a_reg[WIDTH-1]);
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor; Ovf is checked when SUB_OVERFLOW_EN is defined.
module tb_nibble_serial_subtractor;

    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
`ifdef SUB_OVERFLOW_EN
    logic             Ovf;
`endif

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Zero      (Zero)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model works on wide signed/unsigned integers, independent of nibble slicing.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t e;
        longint ua, ub, sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = sa - sb - longint'(bin);
        e.diff = WIDTH'(ua - ub - longint'(bin));
        e.bout = (ua < ub + longint'(bin));
        e.zero = (e.diff == '0);
        e.ovf  = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        scoreboard.push_back(model(a, b, bin));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || Diff !== '0 || Bout !== 1'b0 || Zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: out_valid=%b Diff=%h Bout=%b Zero=%b, required 0/0000/0/0",
                     out_valid, Diff, Bout, Zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va[4] = '{16'h0000, 16'h0005, 16'h0000, 16'h1234};
        logic [WIDTH-1:0] vb[4] = '{16'h0000, 16'h0003, 16'h0001, 16'h1233};
        logic             vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0] want_diff[4] = '{16'h0000, 16'h0002, 16'hFFFF, 16'h0000};
        logic             want_bout[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic             want_zero[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 4; i++) begin
            send_op(va[i], vb[i], vc[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL calc_in_ready[%0d]: got %b, required 0", i, in_ready);
            end
            wait_out(cyc);
            checks++;
            if (cyc != LATENCY) begin
                errors++;
                $display("[TB] FAIL latency[%0d]: got %0d cycles, required %0d", i, cyc, LATENCY);
            end
            e = scoreboard.pop_front();
            checks++;
            if (Diff !== want_diff[i] || Bout !== want_bout[i] || Zero !== want_zero[i]
                || e.diff !== want_diff[i]) begin
                errors++;
                $display("[TB] FAIL directed[%0d]: Diff=%h Bout=%b Zero=%b, required %h/%b/%b",
                         i, Diff, Bout, Zero, want_diff[i], want_bout[i], want_zero[i]);
            end
`ifdef SUB_OVERFLOW_EN
            checks++;
            if (Ovf !== e.ovf) begin
                errors++;
                $display("[TB] FAIL directed_ovf[%0d]: got %b, required %b", i, Ovf, e.ovf);
            end
`endif
            consume();
            checks++;
            if (out_valid !== 1'b0 || Zero !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL after_consume[%0d]: out_valid=%b Zero=%b in_ready=%b, required 0/0/1",
                         i, out_valid, Zero, in_ready);
            end
        end
    endtask

    task automatic test_backpressure_ignore();
        exp_t e;
        int   cyc;
        send_op(16'hABCD, 16'h1234, 1'b1);
        A = 16'hFFFF;
        B = 16'h0000;
        Bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cyc);
        e = scoreboard.pop_front();
        checks++;
        if (cyc > 19) begin
            errors++;
            $display("[TB] FAIL bp_timeout: out_valid never rose");
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = (k == 1);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || Diff !== e.diff || Bout !== e.bout || Zero !== e.zero) begin
                errors++;
                $display("[TB] FAIL backpressure[%0d]: out_valid=%b Diff=%h Bout=%b, required 1/%h/%b",
                         k, out_valid, Diff, Bout, e.diff, e.bout);
            end
        end
        in_valid = 1'b0;
        consume();
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignored_pulse: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   cyc;
        int   stray = 0;
        send_op(16'h5555, 16'h1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(scoreboard.pop_back());
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Diff !== '0) begin
            errors++;
            $display("[TB] FAIL abort_calc: out_valid=%b in_ready=%b Diff=%h, required 0/1/0000",
                     out_valid, in_ready, Diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL abort_partial: out_valid high %0d cycles, required 0", stray);
        end
        send_op(16'h0003, 16'h0001, 1'b0);
        wait_out(cyc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(scoreboard.pop_back());
        checks++;
        if (out_valid !== 1'b0 || Diff !== '0 || Bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_done: out_valid=%b Diff=%h Bout=%b, required 0/0000/0", out_valid, Diff, Bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_op(16'h8000, 16'h0001, 1'b0);
        wait_out(cyc);
        e = scoreboard.pop_front();
        checks++;
        if (cyc != LATENCY || Diff !== 16'h7FFF || Diff !== e.diff || Bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_abort: cycles=%0d Diff=%h Bout=%b, required %0d/7fff/0", cyc, Diff, Bout, LATENCY);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (Ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_8000: got %b, required 1", Ovf);
        end
`endif
        consume();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 4 == 0) ? ra : WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            send_op(ra, rb, rc);
            wait_out(cyc);
            e = scoreboard.pop_front();
            checks++;
            if (cyc != LATENCY || Diff !== e.diff || Bout !== e.bout || Zero !== e.zero) begin
                errors++;
                $display("[TB] FAIL random[%0d]: A=%h B=%h Bin=%b cycles=%0d Diff=%h Bout=%b Zero=%b, required %0d/%h/%b/%b",
                         i, ra, rb, rc, cyc, Diff, Bout, Zero, LATENCY, e.diff, e.bout, e.zero);
            end
`ifdef SUB_OVERFLOW_EN
            checks++;
            if (Ovf !== e.ovf) begin
                errors++;
                $display("[TB] FAIL random_ovf[%0d]: got %b, required %b", i, Ovf, e.ovf);
            end
`endif
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", scoreboard.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, >= 4.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operands present.
REQ-004 SHALL have port in_ready, output, 1, block can accept operands.
REQ-005 SHALL have port A, input, WIDTH, minuend.
REQ-006 SHALL have port B, input, WIDTH, subtrahend.
REQ-007 SHALL have port Bin, input, 1, borrow-in.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port Diff, output, WIDTH, (A - B - Bin) mod 2^WIDTH.
REQ-011 SHALL have port Bout, output, 1, borrow-out: 1 iff A < B + Bin (unsigned).
REQ-012 SHALL have port Zero, output, 1, Diff == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1, SHALL latch A, B and Bin, clear nibble index, and go to CALC.
REQ-015 CALC: per cycle, SHALL compute one 4-bit nibble (LSB first) using the registered borrow; nibble result SHALL go to Diff[4i+3:4i] and borrow to the borrow register.
REQ-016 After nibble WIDTH/4-1, SHALL go to DONE; latency from accept to out_valid=1 SHALL be exactly WIDTH/4 cycles (4 for default).
REQ-017 DONE: out_valid=1, with Diff/Bout/Zero stable; on out_ready=1, SHALL go to IDLE next cycle.
REQ-018 in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored and the operands left unlatched.
REQ-019 out_ready=0 in DONE SHALL hold all outputs unchanged indefinitely (backpressure).
REQ-020 Nibble index SHALL wrap only via the transition to DONE; the index SHALL never exceed WIDTH/4-1.
REQ-021 Zero SHALL be valid only while out_valid=1 and SHALL be 0 otherwise.
REQ-022 Arithmetic per nibble: a + ~b + ~borrow_in; borrow_out = ~carry_out.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, Diff=0, Bout=0, Zero=0, index=0, and borrow register=0.
REQ-024 Reset asserted in CALC or DONE SHALL abort the operation; no partial result SHALL be presented.

Configuration
REQ-025 Macro SUB_OVERFLOW_EN: when defined, SHALL add output port Ovf (1 bit), the signed two's-complement overflow of A - B - Bin, valid with out_valid, reset 0, and 0 when out_valid=0.
REQ-026 Without SUB_OVERFLOW_EN, Ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package cla_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the constant NIBBLE_W=4.
REQ-028 SHALL instantiate one combinational sub-module cla_sub_slice_4bit (a, b, bin -> d, bout) using generate/propagate lookahead internally.

Verification
REQ-029 A=0x0000, B=0x0000, Bin=0 -> after 4 cycles, Diff=0x0000, Bout=0, Zero=1.
REQ-030 A=0x0005, B=0x0003, Bin=0 -> Diff=0x0002, Bout=0, Zero=0.
REQ-031 A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1; A=0x1234, B=0x1233, Bin=1 -> Diff=0x0000, Zero=1, Bout=0.
REQ-032 Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and Diff held; in_valid pulses during CALC/DONE are ignored.
REQ-033 rst_n pulsed in cycle 2 of CALC -> out_valid=0 and state IDLE; the next operation's result is correct.
REQ-034 With SUB_OVERFLOW_EN, A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Ovf=1; A=0x0003, B=0x0001 -> Ovf=0.
